// File: rtl/sram_ctrl_pkg.sv
// Shared widths, request/state types and the granule mask helper for the RW0 SRAM requester.
package sram_ctrl_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 48;
    localparam int MASK_W = 8;
    localparam int GRAN   = DATA_W / MASK_W;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // Spread one enable bit per granule across the whole data word.
    function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] mask);
        logic [DATA_W-1:0] bits;
        bits = '0;
        for (int g = 0; g < MASK_W; g++) begin
            bits[g*GRAN +: GRAN] = {GRAN{mask[g]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; push and pop may coincide when full or empty.
module sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_rw0_ctrl.sv
// Requester for a single-port masked SRAM (RW0): issue muxing, read capture and credit-limited responses.
// Optional SRAM_CTRL_INIT_EN adds a post-reset zero-fill sweep of every address before requests are taken.
module sram_rw0_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 48,
    parameter int MASK_W    = 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    import sram_ctrl_pkg::*;

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic             r_rd_pend;
    logic             r_init_done;
    logic             w_fire;
    logic             w_credit_ok;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_sweeping;
    logic [ADDR_W-1:0] w_sweep_addr;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [0:0] S_INIT = ST_INIT;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]        r_state;
    logic              r_live;
    logic [ADDR_W-1:0] r_sweep;

    // r_live keeps the sweep off the macro until the first edge after reset release.
    assign w_sweeping   = r_live & (r_state == S_INIT);
    assign w_sweep_addr = r_sweep;

    // Init FSM: one zero write per cycle, then hand over to requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_INIT;
            r_live      <= 1'b0;
            r_sweep     <= {ADDR_W{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_sweeping) begin
                r_sweep <= r_sweep + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (r_sweep == {ADDR_W{1'b1}}) begin
                    r_state     <= S_RUN;
                    r_init_done <= 1'b1;
                end else begin
                    r_state     <= r_state;
                    r_init_done <= r_init_done;
                end
            end else begin
                r_sweep     <= r_sweep;
                r_state     <= r_state;
                r_init_done <= r_init_done;
            end
        end
    end
`else
    assign w_sweeping   = 1'b0;
    assign w_sweep_addr = {ADDR_W{1'b0}};

    // Ready from the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end
`endif

    // Credit counts only registered state, so a same-cycle pop does not free a slot.
    assign w_credit_ok = ~w_fifo_full &
                         (({1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, r_rd_pend}) < (CNT_W+1)'(RSP_DEPTH));
    assign req_ready   = r_init_done & (req_write | w_credit_ok);
    assign w_fire      = req_valid & req_ready;
    assign init_done   = r_init_done;
    assign rsp_valid   = ~w_fifo_empty;
    assign w_pop       = rsp_valid & rsp_ready;

    // Macro command mux: init sweep has priority, otherwise the accepted request.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = {ADDR_W{1'b0}};
        RW0_wmask = {MASK_W{1'b0}};
        RW0_wdata = {DATA_W{1'b0}};
        if (w_sweeping) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = w_sweep_addr;
            RW0_wmask = {MASK_W{1'b1}};
            RW0_wdata = {DATA_W{1'b0}};
        end else begin
            RW0_en    = w_fire;
            RW0_wmode = req_write;
            RW0_addr  = req_addr;
            if (req_write) begin
                RW0_wmask = req_mask;
                RW0_wdata = req_wdata;
            end else begin
                RW0_wmask = {MASK_W{1'b0}};
                RW0_wdata = {DATA_W{1'b0}};
            end
        end
    end

    // Marks the cycle in which RW0_rdata holds the data of a read issued last cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_fire & ~req_write;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (r_rd_pend),
        .push_data (RW0_rdata),
        .pop       (w_pop),
        .head      (rsp_rdata),
        .count     (w_fifo_cnt),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
